mem_ctrl: RTL
=============

# mem_ctrl

Arbiter and sequencer for the single byte-wide RAM/IO port, shared between instruction fetch (32-bit instruction reads) and the load/store buffer (1/2/4-byte loads and stores). It accepts one request at a time, splits it into per-byte RAM accesses, assembles or serialises data, and returns a one-cycle completion pulse. It sits between iFetch/LSB and the top-level `mem_*` pins.

## Interface
- No parameters; RAM read latency fixed at 1 cycle, IO space is addr[17:16]==2'b11.
- clk  in  1  system clock; single clock domain.
- rst_in  in  1  reset, asynchronous, active-low.
- rdy_in  in  1  high = run; low = freeze.
- roll_back  in  1  misprediction flush.
- if_en_in  in  1  fetch request, level-held until if_done_out.
- if_addr_in  in  32  instruction address.
- if_done_out  out  1  one-cycle pulse, if_instr_out valid.
- if_instr_out  out  32  fetched instruction, little-endian.
- lsb_en_in  in  1  LSB request, level-held until lsb_done_out.
- lsb_wr_in  in  1  1 = store, 0 = load.
- lsb_len_in  in  2  0: 1 byte, 1: 2 bytes, 2/3: 4 bytes.
- lsb_addr_in  in  32  access address.
- lsb_data_in  in  32  store data, low bytes used.
- lsb_done_out  out  1  one-cycle pulse.
- lsb_data_out  out  32  load data, zero-extended (LSB sign-extends).
- mem_din  in  8  RAM read byte.
- mem_dout  out  8  RAM write byte.
- mem_a  out  32  RAM byte address.
- mem_wr  out  1  1 = write.
- io_buffer_full  in  1  UART buffer full.

## Operation
- States: IDLE, IF_RD, LS_RD, LS_WR. Reset: IDLE, all outputs 0, last_grant = LSB (first contested grant goes to fetch).
- Accept only in IDLE and only when neither done output is high this cycle (mandatory turnaround so requesters can drop enable).
- Arbitration: single requester wins; both requesting → grant the one not equal to last_grant; last_grant updated on accept.
- On accept latch base address, length n (fetch n=4), store data; byte index counters a_idx (address) and c_idx (capture) = 0.
- Reads: present mem_a = base + a_idx, mem_wr=0, a_idx++ while a_idx<n; capture mem_din into byte c_idx one cycle after its address was presented; when c_idx reaches n, pulse done with assembled data, return IDLE, mem_a=0.
- Writes: per cycle drive mem_a = base+k, mem_dout = data[8k+7:8k], mem_wr=1; done pulses the cycle after last byte. If address is IO space and io_buffer_full=1, that cycle drives mem_wr=0 and does not advance.
- roll_back (rdy_in high): aborts IF_RD or LS_RD → IDLE, no done, mem_wr=0; LS_WR continues to completion (committed stores). In IDLE, roll_back blocks acceptance of fetches and loads that cycle; stores may still be accepted.
- rdy_in low: all registers hold, mem_wr forced 0. On resume during a read, a_idx rewinds to c_idx (stale mem_din never captured), costing one extra cycle.
- Address arithmetic 32-bit, wraps modulo 2^32.

## Timing
- Accept edge = end of cycle T. Byte k address on mem_a during cycle T+1+k.
- Read of n bytes: done_out high in cycle T+2+n (fetch: T+6; byte load: T+3), data valid same cycle only.
- Write of n bytes: mem_wr high cycles T+1..T+n; done high in cycle T+1+n; each IO-full stall adds one cycle.
- Earliest next accept: end of cycle after the done cycle.
- Async reset mid-operation: immediate IDLE, outputs 0, no done pulse.

## Test plan
- Fetch only, if_addr_in=0x1000, RAM bytes 13,05,00,00 → mem_a 0x1000..0x1003 cycles T+1..T+4, if_done_out in T+6, if_instr_out=0x00000513.
- Fetch and 4-byte load requested same cycle after reset → fetch served first, load accepted two cycles after if_done_out; swap on next contention.
- Store len=1 data 0x41 to 0x30000 with io_buffer_full high 3 cycles → mem_wr=0 for 3 cycles, then single write 0x41, lsb_done_out next cycle.
- roll_back in cycle T+3 of fetch → no if_done_out, IDLE, mem_wr stays 0; roll_back during 4-byte store → all 4 bytes written, done pulses.
- rdy_in low two cycles mid 2-byte load at 0x2001 → resumes, lsb_data_out equals RAM {[0x2002],[0x2001]}, one extra cycle latency.
- rst_in low mid-store → all outputs 0 immediately, next request served normally.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbiter and byte sequencer for the shared RAM/IO port.
// Fetch and LSB requests are split into single-byte accesses.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        roll_back,
  input  logic        if_en_in,
  input  logic [31:0] if_addr_in,
  output logic        if_done_out,
  output logic [31:0] if_instr_out,
  input  logic        lsb_en_in,
  input  logic        lsb_wr_in,
  input  logic [1:0]  lsb_len_in,
  input  logic [31:0] lsb_addr_in,
  input  logic [31:0] lsb_data_in,
  output logic        lsb_done_out,
  output logic [31:0] lsb_data_out,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);
  typedef enum logic [1:0] {
    IDLE, IF_RD, LS_RD, LS_WR
  } state_t;

  state_t      r_st;
  logic [31:0] r_base;
  logic [31:0] r_wdata;
  logic [31:0] r_buf;
  logic [31:0] r_mem_a;
  logic [31:0] r_if_instr;
  logic [31:0] r_ls_data;
  logic [7:0]  r_dout;
  logic [2:0]  r_n;
  logic [2:0]  r_a;
  logic [2:0]  r_c;
  logic        r_avld;
  logic        r_dvld;
  logic        r_frz;
  logic        r_last_ls;
  logic        r_wr;
  logic        r_if_done;
  logic        r_ls_done;

  logic        w_rd;
  logic        w_stall;
  logic        w_if_req;
  logic        w_ls_req;
  logic        w_can;
  logic        w_gnt_if;
  logic        w_gnt_ls;
  logic        w_cap;
  logic        w_last;
  logic        w_cur_vld;
  logic [2:0]  w_next;
  logic [2:0]  w_lsn;
  logic [2:0]  w_k1;
  logic [7:0]  w_wbyte;
  logic [31:0] w_addr;
  logic [31:0] w_buf;

  assign w_rd = (r_st == IF_RD) || (r_st == LS_RD);
  assign w_stall = (r_mem_a[17:16] == 2'b11) && io_buffer_full;
  assign w_if_req = if_en_in && !roll_back;
  assign w_ls_req = lsb_en_in && (lsb_wr_in || !roll_back);
  assign w_can = (r_st == IDLE) && !r_if_done && !r_ls_done;
  assign w_gnt_ls = w_can && w_ls_req && (!w_if_req || !r_last_ls);
  assign w_gnt_if = w_can && w_if_req && !w_gnt_ls;
  assign w_addr = w_gnt_ls ? lsb_addr_in : if_addr_in;
  assign w_lsn = (lsb_len_in == 2'd0) ? 3'd1 :
                 (lsb_len_in == 2'd1) ? 3'd2 : 3'd4;

  // After a freeze the byte on mem_din is stale; re-present c_idx.
  assign w_cap = !r_frz && r_dvld;
  assign w_last = (r_c == r_n - 3'd1);
  assign w_next = r_frz ? r_c + 3'd1 : r_a;
  assign w_cur_vld = r_frz || r_avld;
  assign w_k1 = r_a + 3'd1;
  assign w_wbyte = r_wdata[{w_k1[1:0], 3'b000} +: 8];

  always_comb begin
    w_buf = r_buf;
    w_buf[{r_c[1:0], 3'b000} +: 8] = mem_din;
  end

  assign mem_a = (w_rd && r_frz) ? r_base + {29'b0, r_c} : r_mem_a;
  assign mem_wr = r_wr && rdy_in && !w_stall;
  assign mem_dout = r_dout;
  assign if_done_out = r_if_done;
  assign if_instr_out = r_if_instr;
  assign lsb_done_out = r_ls_done;
  assign lsb_data_out = r_ls_data;

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      r_st <= IDLE;
      r_base <= '0;
      r_wdata <= '0;
      r_buf <= '0;
      r_mem_a <= '0;
      r_if_instr <= '0;
      r_ls_data <= '0;
      r_dout <= '0;
      r_n <= '0;
      r_a <= '0;
      r_c <= '0;
      r_avld <= 1'b0;
      r_dvld <= 1'b0;
      r_frz <= 1'b0;
      r_last_ls <= 1'b1;
      r_wr <= 1'b0;
      r_if_done <= 1'b0;
      r_ls_done <= 1'b0;
    end else if (!rdy_in) begin
      if (w_rd) r_frz <= 1'b1;
    end else begin
      r_if_done <= 1'b0;
      r_ls_done <= 1'b0;
      unique case (r_st)
        IDLE: begin
          if (w_gnt_if || w_gnt_ls) begin
            r_last_ls <= w_gnt_ls;
            r_base <= w_addr;
            r_mem_a <= w_addr;
            r_n <= w_gnt_ls ? w_lsn : 3'd4;
            r_wdata <= lsb_data_in;
            r_buf <= '0;
            r_c <= '0;
            r_avld <= 1'b1;
            r_dvld <= 1'b0;
            r_frz <= 1'b0;
            if (w_gnt_ls && lsb_wr_in) begin
              r_st <= LS_WR;
              r_a <= 3'd0;
              r_wr <= 1'b1;
              r_dout <= lsb_data_in[7:0];
            end else begin
              r_st <= w_gnt_ls ? LS_RD : IF_RD;
              r_a <= 3'd1;
            end
          end
        end
        IF_RD, LS_RD: begin
          if (roll_back) begin
            r_st <= IDLE;
            r_mem_a <= '0;
            r_avld <= 1'b0;
            r_dvld <= 1'b0;
            r_frz <= 1'b0;
          end else if (w_cap && w_last) begin
            r_st <= IDLE;
            r_buf <= w_buf;
            r_mem_a <= '0;
            r_avld <= 1'b0;
            r_dvld <= 1'b0;
            if (r_st == IF_RD) begin
              r_if_done <= 1'b1;
              r_if_instr <= w_buf;
            end else begin
              r_ls_done <= 1'b1;
              r_ls_data <= w_buf;
            end
          end else begin
            if (w_cap) begin
              r_buf <= w_buf;
              r_c <= r_c + 3'd1;
            end
            r_dvld <= w_cur_vld;
            r_frz <= 1'b0;
            if (w_next < r_n) begin
              r_mem_a <= r_base + {29'b0, w_next};
              r_a <= w_next + 3'd1;
              r_avld <= 1'b1;
            end else begin
              r_mem_a <= '0;
              r_a <= w_next;
              r_avld <= 1'b0;
            end
          end
        end
        LS_WR: begin
          if (!w_stall) begin
            if (w_k1 < r_n) begin
              r_a <= w_k1;
              r_mem_a <= r_base + {29'b0, w_k1};
              r_dout <= w_wbyte;
            end else begin
              r_st <= IDLE;
              r_wr <= 1'b0;
              r_mem_a <= '0;
              r_dout <= '0;
              r_ls_done <= 1'b1;
            end
          end
        end
      endcase
    end
  end
endmodule
